// File: rtl/surf_dna_sequencer_if.sv
// +----------------------------------------------------------------------------+
// | surf_dna_sequencer_if : request/status bundle between the DNA sequencer   |
// | and the ID/control register block.                 Rev 1.0 - initial      |
// +----------------------------------------------------------------------------+
`default_nettype none

interface surf_dna_sequencer_if;
  logic        start_i;
  logic        busy_o;
  logic        valid_o;
  logic [95:0] dna_o;
  logic        mismatch_o;

  modport slave (
    input  start_i,
    output busy_o,
    output valid_o,
    output dna_o,
    output mismatch_o
  );

  modport master (
    output start_i,
    input  busy_o,
    input  valid_o,
    input  dna_o,
    input  mismatch_o
  );
endinterface

`default_nettype wire

// File: rtl/surf_dna_sequencer.sv
// +----------------------------------------------------------------------------+
// | surf_dna_sequencer : drives DNA_PORTE2 (one READ, 96 SHIFTs) and captures |
// | the 96-bit device DNA. SURF_DNA_VERIFY_EN adds a second compare pass.     |
// | Rev 1.0 - initial                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module surf_dna_sequencer #(
  parameter int CLK_DIV    = 4,
  parameter bit AUTO_START = 1'b1
) (
  input  wire logic             wb_clk_i,
  input  wire logic             wb_rst_i,
  surf_dna_sequencer_if.slave   bus,
  output logic                  dna_read_o,
  output logic                  dna_shift_o,
  input  wire logic             dna_dout_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);
  localparam logic [6:0] c_last_bit = 7'd95;

  state_t      r_state;
  logic [7:0]  r_div;
  logic [6:0]  r_bitcnt;
  logic        r_auto;
  logic        r_busy;
  logic        r_valid;
  logic [95:0] r_dna;

  logic w_div_hit;
  logic w_last;

  // The divider counts edges since the last strobe (or the READ cycle).
  assign w_div_hit = (r_div == c_div_last);
  assign w_last    = (r_state == S_SHIFT) && (r_bitcnt == c_last_bit);

`ifdef SURF_DNA_VERIFY_EN
  logic r_pass;
  logic r_miss;
  logic r_mismatch;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_div       <= 8'd0;
      r_bitcnt    <= 7'd0;
      r_auto      <= AUTO_START;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_dna       <= 96'h0;
      dna_read_o  <= 1'b0;
      dna_shift_o <= 1'b0;
      r_pass      <= 1'b0;
      r_miss      <= 1'b0;
      r_mismatch  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_i || r_auto) begin
            r_state    <= S_READ;
            r_auto     <= 1'b0;
            r_busy     <= 1'b1;
            r_valid    <= 1'b0;
            dna_read_o <= 1'b1;
            r_bitcnt   <= 7'd0;
            r_div      <= 8'd0;
            r_pass     <= 1'b0;
            r_miss     <= 1'b0;
            r_mismatch <= 1'b0;
          end
        end
        S_READ, S_WAIT, S_SHIFT: begin
          dna_read_o <= 1'b0;
          if (r_state == S_SHIFT) begin
            // Second pass only compares; the first-pass capture is kept.
            if (r_pass)
              r_miss <= r_miss | (dna_dout_i != r_dna[r_bitcnt]);
            else
              r_dna[r_bitcnt] <= dna_dout_i;
            r_bitcnt <= r_bitcnt + 7'd1;
          end
          if (w_last) begin
            dna_shift_o <= 1'b0;
            r_div       <= 8'd0;
            if (!r_pass) begin
              r_pass     <= 1'b1;
              r_state    <= S_READ;
              dna_read_o <= 1'b1;
              r_bitcnt   <= 7'd0;
            end else begin
              r_state    <= S_DONE;
              r_busy     <= 1'b0;
              r_valid    <= 1'b1;
              r_mismatch <= r_miss | (dna_dout_i != r_dna[r_bitcnt]);
            end
          end else if (w_div_hit) begin
            dna_shift_o <= 1'b1;
            r_div       <= 8'd0;
            r_state     <= S_SHIFT;
          end else begin
            dna_shift_o <= 1'b0;
            r_div       <= r_div + 8'd1;
            r_state     <= S_WAIT;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mismatch_o = r_mismatch;
`else
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_div       <= 8'd0;
      r_bitcnt    <= 7'd0;
      r_auto      <= AUTO_START;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_dna       <= 96'h0;
      dna_read_o  <= 1'b0;
      dna_shift_o <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_i || r_auto) begin
            r_state    <= S_READ;
            r_auto     <= 1'b0;
            r_busy     <= 1'b1;
            r_valid    <= 1'b0;
            dna_read_o <= 1'b1;
            r_bitcnt   <= 7'd0;
            r_div      <= 8'd0;
          end
        end
        S_READ, S_WAIT, S_SHIFT: begin
          dna_read_o <= 1'b0;
          // DOUT still presents the current bit on the edge that ends a strobe.
          if (r_state == S_SHIFT) begin
            r_dna[r_bitcnt] <= dna_dout_i;
            r_bitcnt        <= r_bitcnt + 7'd1;
          end
          if (w_last) begin
            dna_shift_o <= 1'b0;
            r_div       <= 8'd0;
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_valid     <= 1'b1;
          end else if (w_div_hit) begin
            dna_shift_o <= 1'b1;
            r_div       <= 8'd0;
            r_state     <= S_SHIFT;
          end else begin
            dna_shift_o <= 1'b0;
            r_div       <= r_div + 8'd1;
            r_state     <= S_WAIT;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mismatch_o = 1'b0;
`endif

  assign bus.busy_o  = r_busy;
  assign bus.valid_o = r_valid;
  assign bus.dna_o   = r_dna;

endmodule

`default_nettype wire

// File: tb/tb_surf_dna_sequencer.sv
// Directed bench: two sequencers (auto-start CLK_DIV=4, manual CLK_DIV=1) against DNA_PORTE2 models.
`default_nettype none

module tb_surf_dna_sequencer;

`ifdef SURF_DNA_VERIFY_EN
  localparam int c_passes = 2;
`else
  localparam int c_passes = 1;
`endif
  localparam logic [95:0] c_v1 = 96'h0123_4567_89AB_CDEF_FEDC_BA98;
  localparam logic [95:0] c_v2 = 96'hFFFF_0000_FFFF_0000_FFFF_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  surf_dna_sequencer_if ifa ();
  surf_dna_sequencer_if ifb ();
  logic rd_a, sh_a, dout_a, rd_b, sh_b, dout_b;

  surf_dna_sequencer #(.CLK_DIV(4), .AUTO_START(1'b1)) u_dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(ifa),
    .dna_read_o(rd_a), .dna_shift_o(sh_a), .dna_dout_i(dout_a));

  surf_dna_sequencer #(.CLK_DIV(1), .AUTO_START(1'b0)) u_dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(ifb),
    .dna_read_o(rd_b), .dna_shift_o(sh_b), .dna_dout_i(dout_b));

  // DNA_PORTE2 models: READ loads, SHIFT moves toward bit 0; the second load
  // after a base mark can be corrupted with flip_mask.
  logic [95:0] val_a = c_v1, val_b = c_v1, flip_mask = 96'h0;
  logic [95:0] sr_a = 96'h0, sr_b = 96'h0;
  int loads_a = 0, loads_b = 0, base_a = 0, base_b = 0;

  always @(posedge clk) begin
    if (rd_a) begin
      sr_a    <= (loads_a - base_a == 1) ? (val_a ^ flip_mask) : val_a;
      loads_a <= loads_a + 1;
    end else if (sh_a) sr_a <= {1'b0, sr_a[95:1]};
    if (rd_b) begin
      sr_b    <= (loads_b - base_b == 1) ? (val_b ^ flip_mask) : val_b;
      loads_b <= loads_b + 1;
    end else if (sh_b) sr_b <= {1'b0, sr_b[95:1]};
  end
  assign dout_a = sr_a[0];
  assign dout_b = sr_b[0];

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_valid(input int d);
    return (c_passes == 2) ? (3 + 192 * d) : (2 + 96 * d);
  endfunction

  // Observation results; times are cycle offsets from the start edge T.
  int o_read, o_shift_first, o_shift_last, o_valid, o_busy_first, o_busy_last, o_nshift;
  logic o_overlap, o_valid_at1, o_mis;
  logic [95:0] o_dna;

  task automatic observe(input int sel, input int pulse_at_shift, input int stop_at_shift);
    logic rd, sh, bz, vl, mis;
    logic [95:0] dn;
    o_read = -1; o_shift_first = -1; o_shift_last = -1; o_valid = -1;
    o_busy_first = -1; o_busy_last = -1; o_nshift = 0;
    o_overlap = 1'b0; o_valid_at1 = 1'b0; o_mis = 1'b0; o_dna = 96'h0;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      ifa.start_i = 1'b0;
      ifb.start_i = 1'b0;
      if (sel == 0) begin
        rd = rd_a; sh = sh_a; bz = ifa.busy_o; vl = ifa.valid_o; dn = ifa.dna_o; mis = ifa.mismatch_o;
      end else begin
        rd = rd_b; sh = sh_b; bz = ifb.busy_o; vl = ifb.valid_o; dn = ifb.dna_o; mis = ifb.mismatch_o;
      end
      if (rd && o_read < 0) o_read = k;
      if (rd && sh) o_overlap = 1'b1;
      if (sh) begin
        o_nshift++;
        if (o_shift_first < 0) o_shift_first = k;
        o_shift_last = k;
      end
      if (bz) begin
        if (o_busy_first < 0) o_busy_first = k;
        o_busy_last = k;
      end
      if (k == 1) o_valid_at1 = vl;
      if (sh && o_nshift == pulse_at_shift) begin
        if (sel == 0) ifa.start_i = 1'b1; else ifb.start_i = 1'b1;
      end
      if (stop_at_shift > 0 && o_nshift == stop_at_shift) return;
      if (vl) begin
        o_valid = k; o_dna = dn; o_mis = mis;
        return;
      end
    end
  endtask

  initial begin
    ifa.start_i = 1'b0;
    ifb.start_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy_a", ifa.busy_o, 0);
    check("rst_valid_a", ifa.valid_o, 0);
    check("rst_dna_a", ifa.dna_o, 0);
    check("rst_read_a", rd_a, 0);
    check("rst_shift_a", sh_a, 0);
    check("rst_mis_a", ifa.mismatch_o, 0);

    // Auto-start after reset release, CLK_DIV=4
    base_a = loads_a;
    rst = 1'b0;
    observe(0, 0, 0);
    check("a_read_t", o_read, 1);
    check("a_shift_first", o_shift_first, 5);
    check("a_valid_t", o_valid, exp_valid(4));
    check("a_nshift", o_nshift, 96 * c_passes);
    check("a_dna", o_dna, c_v1);
    check("a_overlap", o_overlap, 0);
    check("a_busy_last", o_busy_last, exp_valid(4) - 1);
    check("a_mis", o_mis, 0);
    repeat (5) @(negedge clk);
    check("a_valid_hold", ifa.valid_o, 1);
    check("a_busy_idle", ifa.busy_o, 0);
    check("b_no_auto_busy", ifb.busy_o, 0);
    check("b_no_auto_valid", ifb.valid_o, 0);

    // Manual start, CLK_DIV=1
    base_b = loads_b;
    ifb.start_i = 1'b1;
    observe(1, 0, 0);
    check("b_read_t", o_read, 1);
    check("b_shift_first", o_shift_first, 2);
    check("b_shift_last", o_shift_last, exp_valid(1) - 1);
    check("b_nshift", o_nshift, 96 * c_passes);
    check("b_valid_t", o_valid, exp_valid(1));
    check("b_busy_first", o_busy_first, 1);
    check("b_busy_last", o_busy_last, exp_valid(1) - 1);
    check("b_dna", o_dna, c_v1);
    check("b_overlap", o_overlap, 0);

    // start_i while busy is ignored
    repeat (3) @(negedge clk);
    base_b = loads_b;
    ifb.start_i = 1'b1;
    observe(1, 40, 0);
    check("b_inj_nshift", o_nshift, 96 * c_passes);
    check("b_inj_valid_t", o_valid, exp_valid(1));
    repeat (3) @(negedge clk);
    check("b_inj_no_rerun", ifb.busy_o, 0);

    // Re-read with a new value while valid is held
    val_b = c_v2;
    base_b = loads_b;
    ifb.start_i = 1'b1;
    observe(1, 0, 0);
    check("b_reread_valid_drop", o_valid_at1, 0);
    check("b_reread_dna", o_dna, c_v2);
    check("b_reread_valid_t", o_valid, exp_valid(1));

    // Asynchronous reset at shift 50 of a running sequence
    val_a = c_v2;
    base_a = loads_a;
    ifa.start_i = 1'b1;
    observe(0, 0, 50);
    check("a_abort_at", o_nshift, 50);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", ifa.busy_o, 0);
    check("abort_valid", ifa.valid_o, 0);
    check("abort_dna", ifa.dna_o, 0);
    check("abort_shift", sh_a, 0);
    check("abort_read", rd_a, 0);
    check("abort_valid_b", ifb.valid_o, 0);
    val_a = c_v1;
    repeat (2) @(negedge clk);
    base_a = loads_a;
    rst = 1'b0;
    observe(0, 0, 0);
    check("a_fresh_read_t", o_read, 1);
    check("a_fresh_valid_t", o_valid, exp_valid(4));
    check("a_fresh_nshift", o_nshift, 96 * c_passes);
    check("a_fresh_dna", o_dna, c_v1);

`ifdef SURF_DNA_VERIFY_EN
    // Second pass sees bit 77 flipped
    val_b = c_v1;
    flip_mask = 96'h0;
    flip_mask[77] = 1'b1;
    base_b = loads_b;
    ifb.start_i = 1'b1;
    observe(1, 0, 0);
    check("v_flip_mis", o_mis, 1);
    check("v_flip_dna", o_dna, c_v1);
    check("v_flip_valid_t", o_valid, exp_valid(1));
    flip_mask = 96'h0;
    base_b = loads_b;
    ifb.start_i = 1'b1;
    observe(1, 0, 0);
    check("v_clean_mis", o_mis, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
